// File: rtl/random_range_gen.sv
// Purpose : uniform pseudorandom value in [min_value, max_value], driven by a free-running Galois LFSR.
// Latency : valid 1..MAX_TRIES edges after the accept edge; error is reported 1 edge after the request.
// Backpr. : none; req is sampled only in IDLE and ignored (not queued) while busy.
//
// Ports:
//   clock, resetn         rising-edge clock, synchronous active-low reset
//   seed_load, seed_in    reseed the LFSR (a zero seed falls back to SEED)
//   req                   request one number; accepted only when idle
//   min_value, max_value  inclusive bounds, latched on accept
//   busy                  high while a draw is in flight
//   valid, num_out        one-cycle result pulse; num_out holds between pulses
//   error                 one-cycle pulse when min_value > max_value
module random_range_gen #(
  parameter int unsigned           WIDTH      = 8,
  parameter int unsigned           LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = 16'hB400,
  parameter logic [LFSR_WIDTH-1:0] SEED       = 16'hACE1,
  parameter int unsigned           MAX_TRIES  = 4
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  req,
  input  logic [WIDTH-1:0]      min_value,
  input  logic [WIDTH-1:0]      max_value,
  output logic                  busy,
  output logic                  valid,
  output logic [WIDTH-1:0]      num_out,
  output logic                  error
);

  localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q;
  logic [LFSR_WIDTH-1:0] lfsr_step;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic [WIDTH-1:0]      span_q, span_d;
  logic [TRY_W-1:0]      try_q, try_d;
  logic [WIDTH-1:0]      num_d;
  logic                  valid_d;
  logic                  error_d;
  logic [WIDTH-1:0]      mask;
  logic [WIDTH-1:0]      cand;

  assign lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // Smear span rightwards so mask is the smallest 2^k-1 covering span.
  // Candidates drawn under this mask are <= 2*span+1, so halving a
  // rejected candidate always lands back inside the range.
  always_comb begin
    mask = span_q;
    for (int i = 1; i < int'(WIDTH); i++) begin
      mask = mask | (span_q >> i);
    end
  end

  // Draw from the LFSR value before this edge's step.
  assign cand = lfsr_q[WIDTH-1:0] & mask;

  assign busy = (state_q == DRAW);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    span_d  = span_q;
    try_d   = try_q;
    num_d   = num_out;
    valid_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (min_value > max_value) begin
            error_d = 1'b1;
          end else begin
            lo_d    = min_value;
            span_d  = max_value - min_value;
            try_d   = '0;
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (cand <= span_q) begin
          num_d   = lo_q + cand;
          valid_d = 1'b1;
          state_d = IDLE;
        end else if (try_q == LAST_TRY) begin
          // Bounded-latency fallback: slight bias is accepted here.
          num_d   = lo_q + (cand >> 1);
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      lfsr_q  <= SEED;
      state_q <= IDLE;
      lo_q    <= '0;
      span_q  <= '0;
      try_q   <= '0;
      num_out <= '0;
      valid   <= 1'b0;
      error   <= 1'b0;
    end else begin
      // Reseeding never lets the LFSR lock up at zero.
      if (seed_load) begin
        lfsr_q <= (seed_in == '0) ? SEED : seed_in;
      end else begin
        lfsr_q <= lfsr_step;
      end
      state_q <= state_d;
      lo_q    <= lo_d;
      span_q  <= span_d;
      try_q   <= try_d;
      num_out <= num_d;
      valid   <= valid_d;
      error   <= error_d;
    end
  end

endmodule

// File: tb/tb_random_range_gen.sv
module tb_random_range_gen;

  localparam int          W    = 8;
  localparam int          LW   = 16;
  localparam logic [15:0] TAPS = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MT   = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        req = 1'b0;
  logic [7:0]  min_value = '0;
  logic [7:0]  max_value = '0;
  logic        busy;
  logic        valid;
  logic [7:0]  num_out;
  logic        error;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  random_range_gen #(
    .WIDTH(W), .LFSR_WIDTH(LW), .TAPS(TAPS), .SEED(SEED), .MAX_TRIES(MT)
  ) dut (
    .clock(clock), .resetn(resetn), .seed_load(seed_load), .seed_in(seed_in),
    .req(req), .min_value(min_value), .max_value(max_value),
    .busy(busy), .valid(valid), .num_out(num_out), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  function automatic logic [7:0] cover_mask(input logic [7:0] span);
    int m;
    m = 0;
    while (m < int'(span)) m = m * 2 + 1;
    return m[7:0];
  endfunction

  // Plays out a whole request from the LFSR value seen by the first draw:
  // returns the value delivered and how many draw edges it takes.
  task automatic predict(input logic [15:0] start, input logic [7:0] lo, input logic [7:0] span,
                         output logic [7:0] val, output int edges);
    logic [15:0] s;
    logic [7:0]  mask;
    logic [7:0]  c;
    bit          done;
    s = start;
    mask = cover_mask(span);
    done = 0;
    val = '0;
    edges = 0;
    for (int i = 0; i < MT; i++) begin
      if (!done) begin
        c = s[7:0] & mask;
        if (c <= span) begin
          val = lo + c;
          edges = i + 1;
          done = 1;
        end else if (i == MT - 1) begin
          val = lo + c / 2;
          edges = MT;
          done = 1;
        end
        s = lfsr_next(s);
      end
    end
  endtask

  logic [15:0] m_lfsr = SEED;
  bit          m_busy = 0;
  bit          m_valid = 0;
  bit          m_error = 0;
  logic [7:0]  m_num = '0;
  logic [7:0]  m_pending = '0;
  int          m_wait = 0;

  always @(posedge clock) begin : model_p
    logic [15:0] nxt;
    if (!resetn) begin
      m_lfsr  = SEED;
      m_busy  = 0;
      m_valid = 0;
      m_error = 0;
      m_num   = '0;
      m_wait  = 0;
    end else begin
      nxt = seed_load ? ((seed_in == 16'h0) ? SEED : seed_in) : lfsr_next(m_lfsr);
      m_valid = 0;
      m_error = 0;
      if (m_busy) begin
        m_wait--;
        if (m_wait == 0) begin
          m_busy  = 0;
          m_valid = 1;
          m_num   = m_pending;
        end
      end else if (req) begin
        if (min_value > max_value) begin
          m_error = 1;
        end else begin
          predict(nxt, min_value, max_value - min_value, m_pending, m_wait);
          m_busy = 1;
        end
      end
      m_lfsr = nxt;
    end
  end

  // ---------------- per-cycle compare ----------------
  bit hist_en = 0;
  int hist[256];
  int n_hist = 0;
  int valid_cnt = 0;
  int busy_run = 0;
  int max_run = 0;

  always @(negedge clock) begin
    check("valid", valid, m_valid);
    check("error", error, m_error);
    check("busy", busy, m_busy);
    check("num_out", num_out, m_num);
    if (valid && error) check("valid_and_error", 1, 0);
    if (valid) valid_cnt++;
    if (busy) begin
      busy_run++;
    end else begin
      if (busy_run > max_run) max_run = busy_run;
      busy_run = 0;
    end
    if (hist_en && valid) begin
      hist[num_out]++;
      n_hist++;
      check("range_3_9", (num_out >= 8'd3 && num_out <= 8'd9), 1);
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int v0;
    for (int i = 0; i < 256; i++) hist[i] = 0;

    // Reset state
    tick(); tick();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_num", num_out, 0);

    // Full range right after reset: first draw sees 16'hE270 -> 0x70
    resetn = 1; req = 1; min_value = 8'd0; max_value = 8'd255;
    tick();
    req = 0;
    check("t2_busy", busy, 1);
    check("t2_valid_early", valid, 0);
    tick();
    check("t2_valid", valid, 1);
    check("t2_num", num_out, 112);

    // span 0: min = max = 37
    req = 1; min_value = 8'd37; max_value = 8'd37;
    tick();
    req = 0;
    check("t1_busy", busy, 1);
    check("t1_valid_early", valid, 0);
    tick();
    check("t1_valid", valid, 1);
    check("t1_num", num_out, 37);
    check("t1_busy_done", busy, 0);
    tick();
    check("t1_valid_pulse", valid, 0);

    // Inverted bounds
    req = 1; min_value = 8'd200; max_value = 8'd10;
    tick();
    req = 0;
    check("t3_error", error, 1);
    check("t3_valid", valid, 0);
    check("t3_busy", busy, 0);
    check("t3_num_hold", num_out, 37);
    tick();
    check("t3_error_pulse", error, 0);

    // Zero seed falls back to SEED
    seed_load = 1; seed_in = 16'h0000;
    tick();
    seed_load = 0; req = 1; min_value = 8'd0; max_value = 8'd255;
    tick();
    req = 0;
    tick();
    check("t5_seed0_valid", valid, 1);
    check("t5_seed0_num", num_out, 112);

    // Explicit seed 16'h1234: first draw sees 16'h091A -> 0x1A
    seed_load = 1; seed_in = 16'h1234;
    tick();
    seed_load = 0; req = 1;
    tick();
    req = 0;
    tick();
    check("t5_seed1234_valid", valid, 1);
    check("t5_seed1234_num", num_out, 26);

    // Long back-to-back run over [3,9]
    tick();
    hist_en = 1; req = 1; min_value = 8'd3; max_value = 8'd9;
    for (int c = 0; c < 60000 && n_hist < 10000; c++) tick();
    req = 0;
    hist_en = 0;
    check("t4_count", (n_hist >= 10000), 1);
    for (int i = 0; i < 8; i++) tick();
    for (int b = 3; b <= 9; b++) begin
      check("t4_hist_low", (hist[b] > 700), 1);
      check("t4_hist_high", (hist[b] < 2200), 1);
    end
    check("t4_max_latency", (max_run >= 1 && max_run <= MT), 1);

    // Reset in the middle of a draw
    req = 1; min_value = 8'd0; max_value = 8'd255;
    tick();
    check("t6_busy", busy, 1);
    resetn = 0;
    tick();
    check("t6_valid", valid, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_num_rst", num_out, 0);
    resetn = 1; req = 0;
    v0 = valid_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("t6_abandoned", valid_cnt - v0, 0);

    // A req held into DRAW is not queued
    req = 1; min_value = 8'd10; max_value = 8'd20;
    v0 = valid_cnt;
    tick();
    check("t6_busy2", busy, 1);
    tick();
    req = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t6_single_valid", valid_cnt - v0, 1);
    check("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
